nsu_vc_arbiter: RTL
===================

Name: nsu_vc_arbiter

Overview:
- Packet-level round-robin scheduler that shares the single NSU ingress port (noc2axi_data / s_is_head / s_is_tail) between REQ_NUM flit sources, e.g. virtual-channel buffers or multiple noc_gen instances.
- Sits in the noc_clk domain, directly in front of noc2axi4_slave.
- Keeps packets atomic (head to tail), honours nsu_busy and ddr_init_done, and guards against over-length packets.

Parameters:
- DATA_WIDTH, 128, flit payload width; flit bus is DATA_WIDTH+1 bits.
- REQ_NUM, 4, number of requesters (2..16).
- FLIT_NUM_MAX, 16, maximum flits per packet, head and tail included.

Ports:
- noc_clk  in  1  clock; every register is clocked on its rising edge.
- noc_rst  in  1  synchronous, active-high reset.
- req_data  in  REQ_NUM*DATA_WIDTH  packed payloads; requester i is slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_valid  in  REQ_NUM  flit valid, one bit per requester.
- req_head  in  REQ_NUM  flit is the packet head.
- req_tail  in  REQ_NUM  flit is the packet tail.
- req_ready  out  REQ_NUM  flit accepted when valid&ready.
- nsu_busy  in  1  NSU cannot start a new packet.
- ddr_init_done  in  1  MIG calibration complete.
- noc2axi_data  out  DATA_WIDTH+1  bit DATA_WIDTH = flit-valid, [DATA_WIDTH-1:0] = payload.
- s_is_head  out  1  head marker, qualified by noc2axi_data[DATA_WIDTH].
- s_is_tail  out  1  tail marker, qualified by noc2axi_data[DATA_WIDTH].
- grant_id  out  $clog2(REQ_NUM)  current or last granted requester.
- err_len  out  1  sticky over-length error.

Behaviour:
- Reset: every output is 0, state = ARB, rr_ptr = REQ_NUM-1, flit_cnt = 0, err_len = 0. Reset mid-packet abandons the packet and emits no tail.
- A requester is eligible when req_valid[i] & req_head[i]. A valid flit without head in ARB is not eligible and is held (ready stays 0).
- States:
  - ARB: if ddr_init_done & ~nsu_busy & any eligible, grant the first eligible index searching rr_ptr+1, rr_ptr+2, ... with wrap modulo REQ_NUM. Then set rr_ptr = grant_id = g and go to XFER. Otherwise stay in ARB.
  - XFER: req_ready[g] = 1, all other ready bits 0. ready is a combinational decode of the state/grant registers only, with no path from req_valid. Each accepted flit increments flit_cnt.
    - Accepted flit with tail: go to ARB and clear flit_cnt.
    - Accepted flit with flit_cnt == FLIT_NUM_MAX-1 and no tail: emit that flit with s_is_tail forced to 1, set err_len, go to DROP.
  - DROP: req_ready[g] = 1 and accepted flits are discarded, with no output. On the accepted tail flit go to ARB.
- nsu_busy and ddr_init_done are sampled only in ARB. A packet already in XFER completes even if nsu_busy rises.
- Output latency: 1 cycle. The flit accepted in cycle t appears on noc2axi_data / s_is_head / s_is_tail at t+1 with bit DATA_WIDTH = 1.
- In any cycle with no accepted flit (including DROP), bit DATA_WIDTH, s_is_head and s_is_tail are 0 and the payload holds its last value.
- Single-flit packet: head and tail on the same flit gives one output flit with s_is_head = s_is_tail = 1, then return to ARB.
- Every packet boundary costs exactly one ARB cycle, so the minimum inter-packet gap is one output bubble.
- req_head asserted on a non-first flit in XFER is forwarded unchanged and is not checked.
- err_len is cleared only by noc_rst.

Decomposition:
- Shared package nsu_pkg: the flit-valid bit index (DATA_WIDTH), the state encoding (ARB/XFER/DROP), and the FLIT_NUM_MAX default. Keep these consistent with noc2axi4_slave.
- One natural sub-module: rr_arbiter. It is a combinational REQ_NUM-way round-robin priority picker taking a request vector and rr_ptr, and returning a one-hot grant plus its index.

Test Plan:
1. ddr_init_done = 0, requester 0 offers a 3-flit packet → req_ready stays 0 and the output bit DATA_WIDTH stays 0. Raise ddr_init_done → three output flits: head on the 1st, tail on the 3rd, payloads in order, first one 2 cycles after ddr_init_done rises.
2. Requesters 0..3 each hold a 2-flit packet continuously → grant order 0,1,2,3,0, each packet contiguous, one bubble between packets.
3. nsu_busy = 1 while requester 2 waits → no grant. Raise nsu_busy mid-packet for requester 1 → its packet still completes to tail.
4. Requester 1 sends a 20-flit packet with FLIT_NUM_MAX = 16:
   - 16 output flits, the 16th with s_is_tail = 1, and err_len = 1.
   - Flits 17..20 are accepted but not output.
   - Next grant goes to requester 2.
5. Single-flit packets (head = tail = 1) from requesters 3 and 0 → two output flits, each with s_is_head = s_is_tail = 1, grant order 3 then 0 from rr_ptr = 2.
6. Assert noc_rst mid-packet after the 2nd of 4 flits → all outputs 0 the next cycle. After release the interrupted requester re-sends from head; the arbiter sits in ARB, rr_ptr = REQ_NUM-1, so requester 0 is granted first.

Source files
------------

// File: rtl/nsu_pkg.sv
// nsu_pkg: shared definitions for the NSU ingress path.
// Flit layout and arbiter state encoding used by noc2axi4_slave too.
package nsu_pkg;

  localparam int NSU_DATA_WIDTH   = 128;
  localparam int NSU_FLIT_VLD     = NSU_DATA_WIDTH;
  localparam int FLIT_NUM_MAX_DEF = 16;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    XFER = 2'd1,
    DROP = 2'd2
  } arb_state_e;

  // The flit-valid flag sits just above the payload.
  function automatic int flit_vld_bit(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/nsu_vc_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Searches ptr+1, ptr+2, ... modulo N and returns one-hot plus index.
module rr_arbiter
  import nsu_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // first requester strictly after the pointer wins
  always_comb begin : pick
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/nsu_vc_arbiter.sv
// nsu_vc_arbiter: packet-atomic round-robin scheduler in front of
// the NSU ingress port; one output register stage, length guard.
module nsu_vc_arbiter
  import nsu_pkg::*;
#(
  parameter int DATA_WIDTH   = 128,
  parameter int REQ_NUM      = 4,
  parameter int FLIT_NUM_MAX = FLIT_NUM_MAX_DEF
) (
  input  logic                          noc_clk,
  input  logic                          noc_rst,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] req_data,
  input  logic [REQ_NUM-1:0]            req_valid,
  input  logic [REQ_NUM-1:0]            req_head,
  input  logic [REQ_NUM-1:0]            req_tail,
  output logic [REQ_NUM-1:0]            req_ready,
  input  logic                          nsu_busy,
  input  logic                          ddr_init_done,
  output logic [DATA_WIDTH:0]           noc2axi_data,
  output logic                          s_is_head,
  output logic                          s_is_tail,
  output logic [$clog2(REQ_NUM)-1:0]    grant_id,
  output logic                          err_len
);

  localparam int IW = $clog2(REQ_NUM);
  localparam int CW = $clog2(FLIT_NUM_MAX + 1);
  localparam int VB = flit_vld_bit(DATA_WIDTH);

  localparam logic [IW-1:0] PTR_RST  = IW'(REQ_NUM - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLIT_NUM_MAX - 1);

  arb_state_e state_q, state_d;

  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          vld_q, vld_d;
  logic          head_q, head_d;
  logic          tail_q, tail_d;

  logic [DATA_WIDTH-1:0] pay_q, pay_d;

  logic [REQ_NUM-1:0] elig;
  logic [REQ_NUM-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;

  logic                  own;
  logic                  acc;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_vld;
  logic                  sel_head;
  logic                  sel_tail;

  // Only a head flit may open a packet.
  assign elig     = req_valid & req_head;
  assign pick_any = |pick_gnt;

  rr_arbiter #(
    .N  (REQ_NUM),
    .IW (IW)
  ) u_rr (
    .req_i (elig),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // granted requester's flit, muxed from the grant register
  always_comb begin
    sel_data = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
    sel_vld  = req_valid[grant_q];
    sel_head = req_head[grant_q];
    sel_tail = req_tail[grant_q];
  end

  // ready decodes state and grant only, never req_valid
  always_comb begin
    req_ready = '0;
    own       = (state_q == XFER) || (state_q == DROP);
    if (own) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign acc = own & sel_vld;

  // next state, grant bookkeeping and the output flit
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    head_d  = 1'b0;
    tail_d  = 1'b0;
    pay_d   = pay_q;
    unique case (state_q)
      ARB: begin
        if (ddr_init_done && !nsu_busy && pick_any) begin
          state_d = XFER;
          grant_d = pick_idx;
          rr_d    = pick_idx;
        end
      end
      XFER: begin
        if (acc) begin
          vld_d  = 1'b1;
          pay_d  = sel_data;
          head_d = sel_head;
          tail_d = sel_tail;
          if (sel_tail) begin
            state_d = ARB;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            // close the packet early, swallow the rest
            tail_d  = 1'b1;
            err_d   = 1'b1;
            state_d = DROP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DROP: begin
        if (acc && sel_tail) begin
          state_d = ARB;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // state, grant and output registers
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q <= ARB;
      grant_q <= '0;
      rr_q    <= PTR_RST;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      pay_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      pay_q   <= pay_d;
    end
  end

  assign noc2axi_data[VB]     = vld_q;
  assign noc2axi_data[VB-1:0] = pay_q;
  assign s_is_head            = head_q;
  assign s_is_tail            = tail_q;
  assign grant_id             = grant_q;
  assign err_len              = err_q;

endmodule
